// File: rtl/dmem_arbiter.sv
// Two-port (CPU / debug) arbiter in front of a single-port data memory, with a bounded wait and a timeout abort.
// Optional macro DMEM_ARB_ROUND_ROBIN_EN: alternate grants on simultaneous requests (default: fixed CPU priority).
module dmem_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cpu_req_i,
    input  logic        cpu_we_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_wdata_i,
    output logic [31:0] cpu_rdata_o,
    output logic        cpu_ack_o,
    output logic        cpu_stall_o,
    input  logic        dbg_req_i,
    input  logic        dbg_we_i,
    input  logic [31:0] dbg_addr_i,
    input  logic [31:0] dbg_wdata_i,
    output logic [31:0] dbg_rdata_o,
    output logic        dbg_ack_o,
    output logic        err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ready_i
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic        r_grant_dbg;
    logic        r_err;
    logic [7:0]  r_wait_cnt;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [31:0] r_cpu_rdata;
    logic [31:0] r_dbg_rdata;

    logic        w_any_req;
    logic        w_pick_dbg;
    logic        w_timeout;

    assign w_any_req = cpu_req_i | dbg_req_i;
    assign w_timeout = (r_wait_cnt == WAIT_LAST);

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    logic r_last_dbg;

    // On a contest the port that lost last time wins; resets to DBG so the CPU wins first.
    assign w_pick_dbg = dbg_req_i & (~cpu_req_i | ~r_last_dbg);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_last_dbg <= 1'b1;
        end else if (r_state == ST_IDLE && w_any_req) begin
            r_last_dbg <= w_pick_dbg;
        end
    end
`else
    assign w_pick_dbg = dbg_req_i & ~cpu_req_i;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_any_req) w_state_next = ST_BUSY;
            ST_BUSY: if (mem_ready_i || w_timeout) w_state_next = ST_RESP;
            ST_RESP: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_grant_dbg <= 1'b0;
            r_err       <= 1'b0;
            r_wait_cnt  <= 8'd0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_cpu_rdata <= 32'd0;
            r_dbg_rdata <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_grant_dbg <= w_pick_dbg;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= w_pick_dbg ? dbg_we_i    : cpu_we_i;
                        r_mem_addr  <= w_pick_dbg ? dbg_addr_i  : cpu_addr_i;
                        r_mem_wdata <= w_pick_dbg ? dbg_wdata_i : cpu_wdata_i;
                        r_wait_cnt  <= 8'd0;
                        r_err       <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    r_wait_cnt <= r_wait_cnt + 8'd1;
                    // A ready in the final wait cycle still counts as a normal completion.
                    if (mem_ready_i) begin
                        r_mem_req <= 1'b0;
                        r_err     <= 1'b0;
                        if (!r_mem_we) begin
                            if (r_grant_dbg) r_dbg_rdata <= mem_rdata_i;
                            else             r_cpu_rdata <= mem_rdata_i;
                        end
                    end else if (w_timeout) begin
                        r_mem_req <= 1'b0;
                        r_err     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cpu_ack_o   = (r_state == ST_RESP) & ~r_grant_dbg;
    assign dbg_ack_o   = (r_state == ST_RESP) &  r_grant_dbg;
    assign err_o       = (r_state == ST_RESP) &  r_err;
    assign cpu_stall_o = cpu_req_i & ~cpu_ack_o;
    assign cpu_rdata_o = r_cpu_rdata;
    assign dbg_rdata_o = r_dbg_rdata;
    assign mem_req_o   = r_mem_req;
    assign mem_we_o    = r_mem_we;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_mem_wdata;

endmodule
